sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The block SHALL have the parameter SYM_FILL, default 3'b111, which is the value driven on data whenever data_valid is low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 count  input  4  number of pattern repetitions; latched when start is accepted.
REQ-006 gap  input  4  number of idle cycles between repetitions; latched when start is accepted.
REQ-007 abort  input  1  synchronous cancel of the transmission in progress.
REQ-008 ready  input  1  downstream accepts the current symbol when ready and data_valid are both high.
REQ-009 data  output  3  current pattern symbol (registered).
REQ-010 data_valid  output  1  data holds a pattern symbol (registered).
REQ-011 busy  output  1  high in SEND and GAP.
REQ-012 done  output  1  one-cycle pulse when the last repetition completes normally.

Function
REQ-013 Pattern, index 0..7: 001, 101, 110, 000, 110, 110, 011, 101. This is fixed, not configurable.
REQ-014 The FSM SHALL have three states: IDLE, SEND and GAP. All outputs SHALL be registered, with no combinational path from input to output.
REQ-015 IDLE: if start=1, abort=0 and count!=0, the block SHALL latch count and gap, set the symbol index to 0 and go to SEND. Effect: data=001 and data_valid=1 on the cycle after start.
REQ-016 A start with count=0 SHALL be ignored: the block stays in IDLE and done is not pulsed.
REQ-017 A start while busy=1 SHALL be ignored.
REQ-018 SEND: data_valid=1 and data=pattern[index].
- ready=0: data and index SHALL hold (no skip, no repeat).
- Accept (ready=1) with index<7: index increments and the next symbol appears the following cycle.
REQ-019 Accept of index 7 with repetitions remaining >1:
- gap!=0: go to GAP, data_valid=0, data=SYM_FILL.
- gap=0: index wraps to 0 and 001 appears the very next cycle (back-to-back patterns).
REQ-020 GAP SHALL last exactly the latched gap value in cycles, with data_valid=0 throughout. It then returns to SEND with index 0.
REQ-021 Accept of index 7 on the last repetition: go to IDLE, data_valid=0, data=SYM_FILL, and done=1 for exactly that first IDLE cycle.
REQ-022 The repetition counter is 4 bits and decrements once per completed pattern. A latched count of 15 SHALL yield exactly 15 patterns, with no wrap.
REQ-023 abort=1 in SEND or GAP SHALL force IDLE the next cycle: data_valid=0, data=SYM_FILL, busy=0, done not pulsed. A partial pattern is abandoned, not completed.
REQ-024 abort=1 together with start=1 in IDLE: abort wins and no transmission starts.
REQ-025 abort in the same cycle as the final accept SHALL suppress done.
REQ-026 A new start is accepted on the cycle done is high, because the block is in IDLE.
REQ-027 busy SHALL be high from the first SEND cycle through the last SEND cycle, including GAP cycles, and low in IDLE.
REQ-028 Each transmitted pattern, presented one symbol per accept, SHALL drive the companion 3-bit detector to flag one sequence per repetition.

Reset
REQ-029 While reset_n=0 the block SHALL hold: state=IDLE, data=SYM_FILL, data_valid=0, busy=0, done=0, index=0, repetition and gap counters=0.
REQ-030 Reset asserted mid-transmission SHALL take effect immediately (asynchronously), with no done and no further symbols.
REQ-031 After reset_n deasserts, the block SHALL need a fresh start to transmit.

Verification
REQ-032 start, count=1, gap=0, ready=1 constant -> symbols 001,101,110,000,110,110,011,101 on 8 consecutive cycles starting 1 cycle after start; done=1 on the 9th; busy high for exactly 8 cycles.
REQ-033 count=2, gap=3, ready=1 -> 8 symbols, 3 cycles with data_valid=0 and data=111, 8 symbols, then done; total busy time 19 cycles.
REQ-034 count=1, ready toggled 1,0,0,1,... -> each symbol held while ready=0; the accepted-symbol stream exactly matches the pattern, with no duplicates or drops.
REQ-035 abort pulsed while data=000 (index 3) -> next cycle data_valid=0, busy=0, done stays 0; a subsequent start restarts at 001.
REQ-036 start with count=0 -> busy, data_valid and done all stay 0; start asserted while busy -> no effect on the sequence or the repetition count.
REQ-037 reset_n pulled low mid-GAP -> outputs return immediately to data=111, data_valid=0, busy=0, done=0 and stay there until the next start.

Source files
------------

// File: rtl/sequence_generator.sv
// Fixed 8-symbol pattern transmitter with repetition count, inter-pattern gap,
// ready/valid handshake and abort. All outputs are registered.
module sequence_generator #(
    parameter logic [2:0] SYM_FILL = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] count,
    input  logic [3:0] gap,
    input  logic       abort,
    input  logic       ready,
    output logic [2:0] data,
    output logic       data_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] rep_q, rep_d;
    logic [3:0] gap_len_q, gap_len_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       done_d;
    logic [2:0] data_d;

    function automatic logic [2:0] pattern(input logic [2:0] i);
        case (i)
            3'd0:    pattern = 3'b001;
            3'd1:    pattern = 3'b101;
            3'd2:    pattern = 3'b110;
            3'd3:    pattern = 3'b000;
            3'd4:    pattern = 3'b110;
            3'd5:    pattern = 3'b110;
            3'd6:    pattern = 3'b011;
            default: pattern = 3'b101;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort && (count != 4'd0)) begin
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    rep_d     = count;
                    gap_len_d = gap;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    rep_d   = 4'd0;
                end else if (ready) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        // Pattern complete: index wraps, one repetition consumed.
                        idx_d = 3'd0;
                        rep_d = rep_q - 4'd1;
                        if (rep_q == 4'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (gap_len_q != 4'd0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_len_q;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d   = IDLE;
                    rep_d     = 4'd0;
                    gap_cnt_d = 4'd0;
                end else if (gap_cnt_q == 4'd1) begin
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_d = (state_d == SEND) ? pattern(idx_d) : SYM_FILL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            rep_q      <= 4'd0;
            gap_len_q  <= 4'd0;
            gap_cnt_q  <= 4'd0;
            data       <= SYM_FILL;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            gap_len_q  <= gap_len_d;
            gap_cnt_q  <= gap_cnt_d;
            data       <= data_d;
            data_valid <= (state_d == SEND);
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: per-cycle comparison against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] count = 4'd0;
    logic [3:0] gap = 4'd0;
    logic [2:0] data;
    logic       data_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    logic [2:0] pat [0:7] = '{3'b001, 3'b101, 3'b110, 3'b000,
                              3'b110, 3'b110, 3'b011, 3'b101};

    sequence_generator #(.SYM_FILL(3'b111)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .abort      (abort),
        .ready      (ready),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: is a transmission live, which symbol, how many patterns left.
    bit m_active = 0;
    bit m_in_gap = 0;
    int m_sym = 0;
    int m_reps_left = 0;
    int m_gap_len = 0;
    int m_gap_left = 0;
    bit m_done = 0;

    always @(posedge clk) begin
        m_done = 0;
        if (!reset_n) begin
            m_active = 0;
            m_in_gap = 0;
            m_sym = 0;
        end else if (!m_active) begin
            if (start && !abort && count != 0) begin
                m_active = 1;
                m_in_gap = 0;
                m_sym = 0;
                m_reps_left = int'(count);
                m_gap_len = int'(gap);
            end
        end else if (abort) begin
            m_active = 0;
            m_in_gap = 0;
        end else if (m_in_gap) begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                m_in_gap = 0;
                m_sym = 0;
            end
        end else if (ready) begin
            if (m_sym < 7) begin
                m_sym++;
            end else begin
                m_reps_left--;
                m_sym = 0;
                if (m_reps_left == 0) begin
                    m_active = 0;
                    m_done = 1;
                end else if (m_gap_len > 0) begin
                    m_in_gap = 1;
                    m_gap_left = m_gap_len;
                end
            end
        end
        #1;
        check("cmp_valid", int'(data_valid), int'(m_active && !m_in_gap));
        check("cmp_data", int'(data), (m_active && !m_in_gap) ? int'(pat[m_sym]) : 7);
        check("cmp_busy", int'(busy), int'(m_active));
        check("cmp_done", int'(done), int'(m_done));
    end

    task automatic go(input logic [3:0] c, input logic [3:0] g);
        start = 1'b1;
        count = c;
        gap = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int nb, ng, nv, na;
        bit seen;
        logic [2:0] acc [$];

        repeat (3) @(negedge clk);
        check("reset_data", int'(data), 7);
        check("reset_valid", int'(data_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single pattern, no back-pressure.
        ready = 1'b1;
        go(4'd1, 4'd0);
        check("p1_first", int'(data), 1);
        for (int i = 0; i < 8; i++) begin
            check("p1_sym", int'(data), int'(pat[i]));
            check("p1_busy", int'(busy), 1);
            @(negedge clk);
        end
        check("p1_lit_sym3", int'(pat[3]), 0);
        check("p1_done", int'(done), 1);
        check("p1_busy_end", int'(busy), 0);
        check("p1_data_end", int'(data), 7);
        @(negedge clk);
        check("p1_done_pulse", int'(done), 0);

        // Two patterns with a 3-cycle gap.
        go(4'd2, 4'd3);
        nb = 0; ng = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) nb++;
            if (busy && !data_valid) begin
                ng++;
                check("p2_gap_data", int'(data), 7);
            end
            if (done) seen = 1;
            else @(negedge clk);
        end
        check("p2_done_seen", int'(seen), 1);
        check("p2_busy_cycles", nb, 19);
        check("p2_gap_cycles", ng, 3);
        @(negedge clk);

        // Back-pressure: ready pattern 1,0,0,1 repeating.
        go(4'd1, 4'd0);
        acc.delete();
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            ready = (i % 4 == 0 || i % 4 == 3);
            if (data_valid && ready) acc.push_back(data);
            @(negedge clk);
            if (done) seen = 1;
        end
        check("p3_done_seen", int'(seen), 1);
        check("p3_accept_count", acc.size(), 8);
        for (int i = 0; i < 8 && i < acc.size(); i++)
            check("p3_accept_sym", int'(acc[i]), int'(pat[i]));
        ready = 1'b1;
        @(negedge clk);

        // Abort on index 3, then restart.
        go(4'd1, 4'd0);
        repeat (3) @(negedge clk);
        check("p4_pre_abort", int'(data), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("p4_abort_valid", int'(data_valid), 0);
        check("p4_abort_busy", int'(busy), 0);
        check("p4_abort_done", int'(done), 0);
        go(4'd1, 4'd0);
        check("p4_restart", int'(data), 1);
        repeat (8) @(negedge clk);
        @(negedge clk);

        // start with count=0 is ignored.
        go(4'd0, 4'd2);
        check("p5_zero_busy", int'(busy), 0);
        check("p5_zero_valid", int'(data_valid), 0);
        check("p5_zero_done", int'(done), 0);

        // start while busy is ignored: still exactly 2 patterns.
        go(4'd2, 4'd1);
        nv = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            start = (i == 4 || i == 8);
            count = 4'd5;
            if (data_valid) nv++;
            @(negedge clk);
            if (done) seen = 1;
        end
        start = 1'b0;
        check("p5_busy_start_done", int'(seen), 1);
        check("p5_busy_start_syms", nv, 16);
        @(negedge clk);

        // Fifteen patterns, no wrap of the repetition counter.
        go(4'd15, 4'd0);
        na = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (data_valid) na++;
            @(negedge clk);
            if (done) seen = 1;
        end
        check("p6_done_seen", int'(seen), 1);
        check("p6_symbols", na, 120);
        @(negedge clk);

        // Asynchronous reset in the middle of a gap.
        go(4'd3, 4'd5);
        repeat (9) @(negedge clk);
        check("p7_in_gap", int'(busy && !data_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("p7_rst_data", int'(data), 7);
        check("p7_rst_valid", int'(data_valid), 0);
        check("p7_rst_busy", int'(busy), 0);
        check("p7_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("p7_stays_idle", int'(busy), 0);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            count = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 3));
            gap = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 2));
            abort = ($urandom_range(0, 63) == 0);
            ready = ($urandom_range(0, 9) < 7);
            reset_n = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
